// File: rtl/fir_result_collector.sv
// fir_result_collector
//
// Receiving end of the FIR output stream. Each valid sample is pushed into
// a small first-word fall-through FIFO. The FIFO head is presented on a
// ready/valid read port. The block also keeps a running sample count, a
// modulo checksum of the accepted samples, and a sticky overflow flag, so a
// host can verify a whole run without tracing every sample.
//
// Parameters
//   DATA_W : sample width (matches FIR out_data)
//   DEPTH  : FIFO entries, a power of 2, minimum 2
//   CNT_W  : width of sample_count and checksum
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   in_data      in   sample from FIR out_data
//   in_data_vld  in   sample qualifier; there is no backpressure
//   clear        in   synchronous clear of FIFO, counter, checksum, overflow
//   rd_data      out  FIFO head sample (don't-care while rd_vld = 0)
//   rd_vld       out  FIFO not empty
//   rd_rdy       in   consumer accepts the head this cycle
//   level        out  occupancy, 0..DEPTH
//   sample_count out  accepted samples, modulo 2^CNT_W
//   checksum     out  sum of accepted samples, modulo 2^CNT_W
//   overflow     out  sticky, set when a sample is dropped
module fir_result_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_vld,
  input  logic                     clear,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sample_count,
  output logic [CNT_W-1:0]         checksum,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Modulo-2^CNT_W accumulate of a zero-extended sample.
  function automatic logic [CNT_W-1:0] csum_add(input logic [CNT_W-1:0] acc,
                                                input logic [DATA_W-1:0] s);
    csum_add = acc + CNT_W'(s);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_fire;
  logic              wr_ok;
  logic              drop;

  assign rd_vld  = (level != '0);
  assign rd_fire = rd_vld & rd_rdy;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign wr_ok   = in_data_vld & ((level < FULL_LVL) | rd_fire);
  assign drop    = in_data_vld & ~wr_ok;
  assign rd_data = mem[rd_ptr];

  // Storage: data only, never reset. clear blocks the write so a sample
  // presented together with clear leaves no trace.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Control state: pointers, occupancy, statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_count <= '0;
      checksum     <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_count <= '0;
      checksum     <= '0;
      overflow     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr       <= wr_ptr + PTR_ONE;
        sample_count <= sample_count + CNT_ONE;
        checksum     <= csum_add(checksum, in_data);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_ok && !rd_fire) begin
        level <= level + LVL_ONE;
      end else if (!wr_ok && rd_fire) begin
        level <= level - LVL_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_result_collector.sv
// Self-checking bench for fir_result_collector. A queue-based reference
// model tracks the expected FIFO contents and statistics; directed
// scenarios also check against fixed expected values.
module tb_fir_result_collector;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_data = '0;
  logic             in_data_vld = 1'b0;
  logic             clear = 1'b0;
  logic             rd_rdy = 1'b0;
  logic [7:0]       rd_data;
  logic             rd_vld;
  logic [LVL_W-1:0] level;
  logic [15:0]      sample_count;
  logic [15:0]      checksum;
  logic             overflow;

  logic [7:0]       in8_data = '0;
  logic             in8_vld = 1'b0;
  logic             clear8 = 1'b0;
  logic             rd8_rdy = 1'b0;
  logic [7:0]       rd8_data;
  logic             rd8_vld;
  logic [LVL_W-1:0] level8;
  logic [7:0]       count8;
  logic [7:0]       csum8;
  logic             ovf8;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mq[$];
  int m_cnt;
  int m_sum;
  bit m_ovf;

  fir_result_collector #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_data_vld(in_data_vld),
    .clear(clear), .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .level(level), .sample_count(sample_count), .checksum(checksum),
    .overflow(overflow)
  );

  fir_result_collector #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_data(in8_data), .in_data_vld(in8_vld),
    .clear(clear8), .rd_data(rd8_data), .rd_vld(rd8_vld), .rd_rdy(rd8_rdy),
    .level(level8), .sample_count(count8), .checksum(csum8),
    .overflow(ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_sum = 0;
    m_ovf = 0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge), advance the
  // model at the rising edge, and return at the next falling edge.
  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
    bit fire;
    bit ok;
    in_data_vld = v;
    in_data     = d;
    rd_rdy      = r;
    clear       = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      fire = (mq.size() > 0) && r;
      ok   = v && ((mq.size() < DEPTH) || fire);
      if (fire) void'(mq.pop_front());
      if (ok) begin
        mq.push_back(int'(d));
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        m_sum = (m_sum + int'(d)) & 16'hFFFF;
      end else if (v) begin
        m_ovf = 1;
      end
    end
    @(negedge clk);
    in_data_vld = 1'b0;
    clear       = 1'b0;
    rd_rdy      = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got %0b want 0", rd_vld); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
    checks++; if (checksum !== 16'd0) begin errors++; $display("FAIL reset_checksum got %0d want 0", checksum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (level8 !== '0 || count8 !== 8'd0 || ovf8 !== 1'b0) begin errors++; $display("FAIL reset_dut8 got level=%0d count=%0d ovf=%0b want 0", level8, count8, ovf8); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      checks++; if (rd_vld !== 1'b1 || rd_data !== 8'(i)) begin errors++; $display("FAIL ramp_data i=%0d got vld=%0b data=%0d want vld=1 data=%0d", i, rd_vld, rd_data, i); end
      checks++; if (level !== LVL_W'(1)) begin errors++; $display("FAIL ramp_level i=%0d got %0d want 1", i, level); end
    end
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (sample_count !== 16'd256) begin errors++; $display("FAIL ramp_count got %0d want 256", sample_count); end
    checks++; if (checksum !== 16'h7F80) begin errors++; $display("FAIL ramp_checksum got %0h want 7f80", checksum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ramp_overflow got %0b want 0", overflow); end
    checks++; if (level !== '0 || rd_vld !== 1'b0) begin errors++; $display("FAIL ramp_empty got level=%0d vld=%0b want 0 0", level, rd_vld); end
  endtask

  task automatic test_overflow();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) begin
        checks++; if (level !== LVL_W'(16) || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full got level=%0d ovf=%0b want 16 0", level, overflow); end
      end
      if (i == 16) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
      end
    end
    checks++; if (sample_count !== 16'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", sample_count); end
    checks++; if (checksum !== 16'd120) begin errors++; $display("FAIL ovf_checksum got %0d want 120", checksum); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (rd_vld !== 1'b1 || rd_data !== 8'(j)) begin errors++; $display("FAIL ovf_drain j=%0d got vld=%0b data=%0d want 1 %0d", j, rd_vld, rd_data, j); end
      drive(1'b0, 8'd0, 1'b1, 1'b0);
    end
    checks++; if (rd_vld !== 1'b0 || level !== '0) begin errors++; $display("FAIL ovf_empty got vld=%0b level=%0d want 0 0", rd_vld, level); end
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (level !== '0) begin errors++; $display("FAIL no_underflow got %0d want 0", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_rw();
    int got[$];
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 16; i < 32; i++) begin
      if (rd_vld === 1'b1) got.push_back(int'(rd_data));
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      checks++; if (level !== LVL_W'(16) || overflow !== 1'b0) begin errors++; $display("FAIL fullrw_level i=%0d got level=%0d ovf=%0b want 16 0", i, level, overflow); end
    end
    for (int i = 0; i < 16; i++) begin
      if (rd_vld === 1'b1) got.push_back(int'(rd_data));
      drive(1'b0, 8'd0, 1'b1, 1'b0);
    end
    checks++; if (got.size() != 32) begin errors++; $display("FAIL fullrw_len got %0d want 32", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] != k) begin errors++; $display("FAIL fullrw_seq k=%0d got %0d want %0d", k, got[k], k); end
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clear_pre_ovf got %0b want 1", overflow); end
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    checks++; if (level !== '0 || rd_vld !== 1'b0) begin errors++; $display("FAIL clear_fifo got level=%0d vld=%0b want 0 0", level, rd_vld); end
    checks++; if (sample_count !== 16'd0 || checksum !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_stats got cnt=%0d sum=%0d ovf=%0b want 0 0 0", sample_count, checksum, overflow); end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (level !== LVL_W'(1) || rd_data !== 8'h3C) begin errors++; $display("FAIL clear_after got level=%0d data=%0h want 1 3c", level, rd_data); end
    checks++; if (sample_count !== 16'd1 || checksum !== 16'h3C) begin errors++; $display("FAIL clear_after_stats got cnt=%0d sum=%0h want 1 3c", sample_count, checksum); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i + 7), 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++; if (rd_vld !== 1'b0 || level !== '0) begin errors++; $display("FAIL areset_fifo got vld=%0b level=%0d want 0 0", rd_vld, level); end
    checks++; if (sample_count !== 16'd0 || checksum !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL areset_stats got cnt=%0d sum=%0d ovf=%0b want 0 0 0", sample_count, checksum, overflow); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    test_ramp();
  endtask

  task automatic test_random();
    bit v, r, c;
    logic [7:0] d;
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      d = 8'($urandom_range(0, 255));
      drive(v, d, r, c);
      checks++; if (level !== LVL_W'(mq.size()) || rd_vld !== (mq.size() > 0)) begin errors++; $display("FAIL rand_level n=%0d got level=%0d vld=%0b want %0d", n, level, rd_vld, mq.size()); end
      if (mq.size() > 0) begin
        checks++; if (rd_data !== 8'(mq[0])) begin errors++; $display("FAIL rand_data n=%0d got %0d want %0d", n, rd_data, mq[0]); end
      end
      checks++; if (sample_count !== 16'(m_cnt) || checksum !== 16'(m_sum) || overflow !== m_ovf) begin errors++; $display("FAIL rand_stats n=%0d got cnt=%0d sum=%0d ovf=%0b want %0d %0d %0b", n, sample_count, checksum, overflow, m_cnt, m_sum, m_ovf); end
    end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      in8_vld = 1'b1;
      in8_data = 8'd1;
      rd8_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (rd8_vld !== 1'b1 || rd8_data !== 8'd1) bad++;
    end
    in8_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd8_rdy = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data got %0d bad reads want 0", bad); end
    checks++; if (count8 !== 8'd44) begin errors++; $display("FAIL wrap_count got %0d want 44", count8); end
    checks++; if (csum8 !== 8'd44) begin errors++; $display("FAIL wrap_checksum got %0d want 44", csum8); end
    checks++; if (level8 !== '0 || ovf8 !== 1'b0) begin errors++; $display("FAIL wrap_end got level=%0d ovf=%0b want 0 0", level8, ovf8); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_overflow();
    test_full_rw();
    test_clear();
    test_async_reset();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
